// File: rtl/sonic_dist_filter.sv
// Filters the ranging stage's raw distance: range gating, 4-sample moving average,
// hysteresis obstacle flag with N-sample confirmation and a sensor-lost detector.
module sonic_dist_filter #(
   parameter int SAMPLE_CYCLES = 10000000,
   parameter int MAX_CM        = 400,
   parameter int NEAR_CM       = 10,
   parameter int FAR_CM        = 15,
   parameter int CONFIRM       = 2,
   parameter int MISS_LIMIT    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] dist_in,
   output logic [19:0] dist_avg,
   output logic        filt_valid,
   output logic        obstacle,
   output logic        sensor_lost
);

   localparam int TW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CYCLES - 1);
   localparam logic [19:0]   MAX_V     = 20'(MAX_CM);
   localparam logic [19:0]   NEAR_V    = 20'(NEAR_CM);
   localparam logic [19:0]   FAR_V     = 20'(FAR_CM);
   localparam logic [3:0]    CONF_V    = 4'(CONFIRM);
   localparam logic [3:0]    MISS_V    = 4'(MISS_LIMIT);

   typedef enum logic [1:0] {CLEAR, BLOCKED, LOST} state_t;

   logic [19:0]      q1, q2;
   logic [TW-1:0]    tick_cnt;
   logic             pend;
   logic [3:0][19:0] win;
   logic [21:0]      sum;
   logic [2:0]       fill;
   logic [3:0]       miss;
   logic             upd;
   state_t           state;
   logic [3:0]       cnt;

   logic        wrap, consume, sample_ok, lost_rise, lost_fall, eval;
   logic [3:0]  miss_nx;
   logic [19:0] oldest, avg;
   logic [21:0] sum_nx;

   assign wrap      = (tick_cnt == TICK_LAST);
   // the input is asynchronous and slow; only sample when two captures agree
   assign consume   = pend && (q1 == q2);
   assign sample_ok = (q2 != 20'd0) && (q2 <= MAX_V);
   assign miss_nx   = (miss == MISS_V) ? miss : miss + 4'd1;
   assign lost_rise = consume && !sample_ok && (miss_nx == MISS_V) && !sensor_lost;
   assign lost_fall = consume && sample_ok && sensor_lost;
   assign oldest    = (fill == 3'd4) ? win[3] : 20'd0;
   assign sum_nx    = sum + {2'b00, q2} - {2'b00, oldest};
   assign eval      = upd && (fill == 3'd4);
   assign avg       = sum[21:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1          <= '0;
         q2          <= '0;
         tick_cnt    <= '0;
         pend        <= 1'b0;
         win         <= '0;
         sum         <= '0;
         fill        <= '0;
         miss        <= '0;
         upd         <= 1'b0;
         dist_avg    <= '0;
         filt_valid  <= 1'b0;
         sensor_lost <= 1'b0;
      end else begin
         q1         <= dist_in;
         q2         <= q1;
         tick_cnt   <= wrap ? '0 : tick_cnt + TW'(1);
         pend       <= wrap || (pend && !consume);
         upd        <= consume && sample_ok;
         filt_valid <= 1'b0;
         if (eval) begin
            dist_avg   <= avg;
            filt_valid <= 1'b1;
         end
         if (consume) begin
            if (sample_ok) begin
               win         <= {win[2:0], q2};
               sum         <= sum_nx;
               fill        <= (fill == 3'd4) ? fill : fill + 3'd1;
               miss        <= '0;
               sensor_lost <= 1'b0;
            end else begin
               miss <= miss_nx;
               if (lost_rise) begin
                  // losing the sensor forces a fresh warm-up
                  sensor_lost <= 1'b1;
                  win         <= '0;
                  sum         <= '0;
                  fill        <= '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLEAR;
         cnt      <= '0;
         obstacle <= 1'b0;
      end else if (lost_rise) begin
         state    <= LOST;
         cnt      <= '0;
         obstacle <= 1'b1;
      end else begin
         case (state)
            CLEAR: if (eval) begin
               if (avg < NEAR_V) begin
                  if (cnt + 4'd1 >= CONF_V) begin
                     state    <= BLOCKED;
                     cnt      <= '0;
                     obstacle <= 1'b1;
                  end else cnt <= cnt + 4'd1;
               end else cnt <= '0;
            end
            BLOCKED: if (eval) begin
               if (avg > FAR_V) begin
                  if (cnt + 4'd1 >= CONF_V) begin
                     state    <= CLEAR;
                     cnt      <= '0;
                     obstacle <= 1'b0;
                  end else cnt <= cnt + 4'd1;
               end else cnt <= '0;
            end
            LOST: if (lost_fall) begin
               // fail-safe: stay blocked until far averages are confirmed
               state <= BLOCKED;
               cnt   <= '0;
            end
            default: begin
               state    <= CLEAR;
               cnt      <= '0;
               obstacle <= 1'b0;
            end
         endcase
      end
   end

endmodule
